// File: rtl/fifo_burst_writer.sv
// fifo_burst_writer: packet-aware write front-end for an async FIFO.
// Upstream words enter a 2-entry skid buffer; a small FSM keeps new packets
// from starting while the FIFO is almost full, but never splits a packet
// once started. Saturating counters report delivered packets and full stalls.
module fifo_burst_writer #(
    parameter int DATASIZE    = 8,
    parameter int PKT_GATE_EN = 1,
    parameter int CNTSIZE     = 16
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATASIZE-1:0] s_data,
    input  logic                s_last,
    output logic                winc,
    output logic [DATASIZE:0]   wdata,
    input  logic                wfull,
    input  logic                walmost_full,
    output logic [CNTSIZE-1:0]  pkt_count,
    output logic [CNTSIZE-1:0]  stall_count,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_AF = 2'd1,
        XFER    = 2'd2
    } state_t;

    localparam logic [CNTSIZE-1:0] CNT_ONE = 1;

    state_t              state_q, state_d;
    logic [DATASIZE:0]   ent0_q, ent0_d;   // oldest entry, drives wdata
    logic [DATASIZE:0]   ent1_q, ent1_d;
    logic [1:0]          occ_q, occ_d;
    logic                s_ready_q;
    logic [CNTSIZE-1:0]  pkt_q, pkt_d;
    logic [CNTSIZE-1:0]  stall_q, stall_d;
    logic                gate_ok;
    logic                push;
    logic                pop;
    logic                nonempty;
    logic [DATASIZE:0]   in_word;

    function automatic logic [CNTSIZE-1:0] sat_inc(input logic [CNTSIZE-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign in_word  = {s_last, s_data};
    assign nonempty = (occ_q != 2'd0);
    // s_ready_q is already low whenever the buffer is full, so push never overflows.
    assign push     = s_valid & s_ready_q;
    assign pop      = winc;

    // State register with asynchronous reset.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: gate packet starts on almost-full, release on last word.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (nonempty) begin
                    if ((PKT_GATE_EN == 0) || !walmost_full) begin
                        if (winc) begin
                            state_d = ent0_q[DATASIZE] ? IDLE : XFER;
                        end
                    end else begin
                        state_d = WAIT_AF;
                    end
                end
            end
            WAIT_AF: begin
                if (!walmost_full) begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (winc && ent0_q[DATASIZE]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: per-state write gate, FIFO write enable and busy flag.
    always_comb begin
        gate_ok = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            IDLE:    gate_ok = (PKT_GATE_EN == 0) || !walmost_full;
            WAIT_AF: gate_ok = 1'b0;
            XFER: begin
                gate_ok = 1'b1;
                busy    = 1'b1;
            end
            default: gate_ok = 1'b0;
        endcase
        winc = nonempty & ~wfull & gate_ok;
    end

    // Skid buffer next state: pop shifts entry 1 forward, push fills the next free slot.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        unique case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    ent0_d = in_word;
                end else begin
                    ent1_d = in_word;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the new word lands behind whatever remains.
                if (occ_q == 2'd1) begin
                    ent0_d = in_word;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = in_word;
                end
            end
            default: begin
                ent0_d = ent0_q;
            end
        endcase
    end

    // Status counters: completed packets and cycles blocked by a full FIFO.
    always_comb begin
        pkt_d   = (winc && ent0_q[DATASIZE]) ? sat_inc(pkt_q) : pkt_q;
        stall_d = (nonempty && wfull && (state_q != WAIT_AF)) ? sat_inc(stall_q) : stall_q;
    end

    // Buffer, ready and counter registers; reset clears any partial packet.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            ent0_q    <= '0;
            ent1_q    <= '0;
            occ_q     <= 2'd0;
            s_ready_q <= 1'b0;
            pkt_q     <= '0;
            stall_q   <= '0;
        end else begin
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            occ_q     <= occ_d;
            s_ready_q <= (occ_d != 2'd2);
            pkt_q     <= pkt_d;
            stall_q   <= stall_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign wdata       = ent0_q;
    assign pkt_count   = pkt_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Directed bench for fifo_burst_writer: main instance with defaults, plus
// a no-gate instance and a 4-bit-counter instance driven by the same inputs.
module tb_fifo_burst_writer;

    logic        wclk;
    logic        wrst_n;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        wfull;
    logic        walmost_full;

    logic        s_ready, winc, busy;
    logic [8:0]  wdata;
    logic [15:0] pkt_count, stall_count;

    logic        g_s_ready, g_winc, g_busy;
    logic [8:0]  g_wdata;
    logic [15:0] g_pkt_count, g_stall_count;

    logic        c_s_ready, c_winc, c_busy;
    logic [8:0]  c_wdata;
    logic [3:0]  c_pkt_count, c_stall_count;

    int checks;
    int failures;
    logic [8:0] got_q[$];
    int stall_zero;

    fifo_burst_writer dut (
        .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .winc(winc), .wdata(wdata),
        .wfull(wfull), .walmost_full(walmost_full), .pkt_count(pkt_count),
        .stall_count(stall_count), .busy(busy)
    );

    fifo_burst_writer #(.PKT_GATE_EN(0)) dut_nogate (
        .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(g_s_ready),
        .s_data(s_data), .s_last(s_last), .winc(g_winc), .wdata(g_wdata),
        .wfull(wfull), .walmost_full(walmost_full), .pkt_count(g_pkt_count),
        .stall_count(g_stall_count), .busy(g_busy)
    );

    fifo_burst_writer #(.CNTSIZE(4)) dut_cnt4 (
        .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(c_s_ready),
        .s_data(s_data), .s_last(s_last), .winc(c_winc), .wdata(c_wdata),
        .wfull(wfull), .walmost_full(walmost_full), .pkt_count(c_pkt_count),
        .stall_count(c_stall_count), .busy(c_busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Log every word the main instance writes; inputs are stable at the falling edge.
    always @(negedge wclk) begin
        if (wrst_n && winc) got_q.push_back(wdata);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        s_valid = v;
        s_data  = d;
        s_last  = l;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        wrst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        wfull = 1'b0;
        walmost_full = 1'b0;

        // Reset values while wrst_n is low.
        #3;
        check_eq("rst_s_ready", s_ready, 0);
        check_eq("rst_winc", winc, 0);
        check_eq("rst_wdata", wdata, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_pkt", pkt_count, 0);
        check_eq("rst_stall", stall_count, 0);
        tick();
        tick();
        wrst_n = 1'b1;
        #1;
        check_eq("ready_before_edge", s_ready, 0);
        tick();
        check_eq("ready_after_release", s_ready, 1);

        // Single 3-word packet A,B,C.
        drive(1'b1, 8'hA1, 1'b0);
        tick();
        check_eq("p3_winc0", winc, 1);
        check_eq("p3_wdata0", wdata, 9'h0A1);
        check_eq("p3_busy0", busy, 0);
        drive(1'b1, 8'hB2, 1'b0);
        tick();
        check_eq("p3_winc1", winc, 1);
        check_eq("p3_wdata1", wdata, 9'h0B2);
        check_eq("p3_busy1", busy, 1);
        drive(1'b1, 8'hC3, 1'b1);
        tick();
        check_eq("p3_winc2", winc, 1);
        check_eq("p3_wdata2", wdata, 9'h1C3);
        drive(1'b0, 8'h00, 1'b0);
        tick();
        check_eq("p3_winc_done", winc, 0);
        check_eq("p3_pkt", pkt_count, 1);
        check_eq("p3_busy_done", busy, 0);
        check_eq("stall_pre", stall_count, 0);

        // wfull for 4 cycles in the middle of a streamed 6-word packet.
        got_q.delete();
        stall_zero = 0;
        begin
            int idx;
            idx = 0;
            for (int c = 0; c < 14; c++) begin
                logic acc;
                wfull = (c >= 2 && c <= 5);
                if (idx < 6) drive(1'b1, 8'h20 + 8'(idx), idx == 5);
                else drive(1'b0, 8'h00, 1'b0);
                #1;
                if (wfull && winc == 1'b0) stall_zero++;
                if (c == 3) check_eq("full_ready_low", s_ready, 0);
                acc = s_valid & s_ready;
                tick();
                if (acc) idx++;
            end
            wfull = 1'b0;
            check_eq("full_all_accepted", idx, 6);
        end
        check_eq("full_winc_low_cycles", stall_zero, 4);
        check_eq("full_stall_count", stall_count, 4);
        check_eq("full_pkt", pkt_count, 2);
        check_eq("full_nwords", got_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            logic [8:0] e;
            e = {(i == 5), 8'h20 + 8'(i)};
            if (i < got_q.size()) check_eq("full_order", got_q[i], e);
        end

        // Almost-full gate in IDLE; the no-gate instance writes immediately.
        walmost_full = 1'b1;
        drive(1'b1, 8'h30, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        #1;
        check_eq("af_idle_winc", winc, 0);
        check_eq("nogate_winc", g_winc, 1);
        check_eq("nogate_wdata", g_wdata, 9'h130);
        tick();
        check_eq("af_wait_winc", winc, 0);
        check_eq("nogate_pkt", g_pkt_count, 3);
        tick();
        check_eq("af_wait_winc2", winc, 0);
        check_eq("af_wait_no_stall", stall_count, 4);
        walmost_full = 1'b0;
        #1;
        check_eq("af_release_cycle_winc", winc, 0);
        tick();
        check_eq("af_first_write", winc, 1);
        check_eq("af_first_wdata", wdata, 9'h130);
        tick();
        check_eq("af_done_winc", winc, 0);
        check_eq("af_pkt", pkt_count, 3);

        // walmost_full rising mid-packet must not interrupt it.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h40 + 8'(i), i == 3);
            walmost_full = (i >= 2);
            #1;
            if (i > 0) begin
                check_eq("xfer_af_winc", winc, 1);
                check_eq("xfer_af_wdata", wdata, {1'b0, 8'h40 + 8'(i - 1)});
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        #1;
        check_eq("xfer_af_last_winc", winc, 1);
        check_eq("xfer_af_last_wdata", wdata, 9'h143);
        tick();
        check_eq("xfer_af_pkt", pkt_count, 4);
        check_eq("xfer_af_idle", busy, 0);
        walmost_full = 1'b0;

        // Reset pulse after 2 of 5 words have been written.
        drive(1'b1, 8'h50, 1'b0);
        tick();
        drive(1'b1, 8'h51, 1'b0);
        tick();
        drive(1'b1, 8'h52, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        wrst_n = 1'b0;
        #1;
        check_eq("mid_rst_winc", winc, 0);
        check_eq("mid_rst_wdata", wdata, 0);
        check_eq("mid_rst_ready", s_ready, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_pkt", pkt_count, 0);
        check_eq("mid_rst_stall", stall_count, 0);
        tick();
        wrst_n = 1'b1;
        #1;
        check_eq("post_rst_winc", winc, 0);
        tick();
        check_eq("post_rst_ready", s_ready, 1);
        check_eq("post_rst_winc2", winc, 0);
        drive(1'b1, 8'h60, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        #1;
        check_eq("post_rst_pkt_winc", winc, 1);
        check_eq("post_rst_pkt_wdata", wdata, 9'h160);
        tick();
        check_eq("post_rst_pkt", pkt_count, 1);

        // 20 single-word packets: 4-bit counter saturates at 15.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(i), 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        check_eq("sat_pkt_cnt4", c_pkt_count, 15);
        check_eq("sat_pkt_main", pkt_count, 21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
